key_event_sched: RTL and testbench
==================================

// Module: key_event_sched
// PURPOSE
//  Scheduler between the 4x4 keypad column scanner and the note/command logic.
//  - Samples each per-row scan result (new-press bits, active low) on the scanner's row-ready pulse.
//  - Serialises multiple simultaneous presses in that row into single key codes, one per clock.
//  - Buffers the codes in a FIFO; consumers drain it over a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH  8  key-code FIFO entries; power of two, 2..64
//  LVL_W       $clog2(FIFO_DEPTH)+1  (localparam) width of fifo_level
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous, active-low reset
//  row_rdy     in   1      one-clk pulse: scanner row result valid
//  row_hi      in   2      row index of that result
//  col_n       in   4      new-press bits, active low; bit i low = column i pressed
//  flush       in   1      synchronous clear of FIFO, pending bits and overflow
//  key_valid   out  1      FIFO head valid
//  key_code    out  4      {row_hi, col_idx} of FIFO head
//  key_ready   in   1      consumer accepts head when key_valid & key_ready
//  fifo_level  out  LVL_W  entries currently stored, 0..FIFO_DEPTH
//  busy        out  1      FSM in SER state
//  overflow    out  1      sticky: a key code or row result was dropped
// BEHAVIOUR
//  Reset (async): state IDLE, pend=0, FIFO empty.
//   key_valid=0, key_code=0, fifo_level=0, busy=0, overflow=0.
//  FSM IDLE:
//   - row_rdy & (col_n!=4'hF): pend<=~col_n, rowq<=row_hi, go SER.
//   - row_rdy & (col_n==4'hF): ignored, stay IDLE.
//  FSM SER, each cycle:
//   - col_idx = lowest set bit of pend; push {rowq,col_idx}; clear that bit.
//   - go IDLE when the last bit is cleared. 1..4 cycles, ascending column order.
//  row_rdy while in SER: the row result is dropped and overflow<=1.
//   Scanner row period is far longer than 4 cycles; this is a fault case only.
//  Latency: row_rdy sampled at edge N -> first push at edge N+1 -> key_valid=1 after edge N+1 if FIFO was empty.
//  FIFO: registered head; key_code holds stable while key_valid & ~key_ready.
//  Pop: key_valid & key_ready. Push: SER cycle.
//   - Push when full with no pop: code dropped, pend bit still cleared, overflow<=1.
//   - Push and pop in the same cycle when full: push accepted, level unchanged.
//   - Pop when empty: impossible (key_valid=0).
//   - Pointers wrap modulo FIFO_DEPTH.
//   - fifo_level = pushes - pops, never exceeds FIFO_DEPTH.
//  flush: highest priority over row_rdy, push and pop in the same cycle.
//   Next cycle: IDLE, pend=0, FIFO empty, overflow=0.
//  Reset asserted mid-SER: all state cleared immediately; remaining pend bits lost.
// CONFIGURATION
//  KEYSCHED_OVF_CNT_EN defined:
//   - adds output ovf_count[7:0]: increments by 1 per dropped code or dropped row result.
//   - saturates at 8'hFF; cleared by flush and by reset.
//   - A dropped row result counts 1, regardless of how many bits it carries.
//  Not defined: port ovf_count absent; only the sticky overflow flag exists.
// TESTING
//  1 Reset, then row_rdy row_hi=2 col_n=4'b1101, key_ready=1
//    -> key_code=4'h9 valid 2 edges after the pulse, one beat only; busy high 1 cycle.
//  2 row_rdy row_hi=1 col_n=4'b0000, key_ready=0
//    -> FIFO holds 4,5,6,7; fifo_level=4; busy 4 cycles; codes popped in that order.
//  3 key_ready=0; three rows of 4 presses each
//    -> level stops at 8, last 4 codes dropped, overflow=1 (ovf_count=4 with macro).
//  4 FIFO full plus SER push coinciding with a pop -> level stays 8, new code appended at tail.
//  5 flush in the 2nd SER cycle of col_n=4'b0000
//    -> next cycle IDLE, level=0, key_valid=0, overflow=0.
//  6 rst_n low mid-SER with 3 queued codes -> all outputs at reset values at once;
//    after release, a fresh row_rdy behaves as test 1.

Source files
------------

// File: rtl/key_event_sched.sv
// Keypad row-result scheduler: serialises per-row press bits into key codes and queues them in a FIFO.
// Optional build macro KEYSCHED_OVF_CNT_EN adds a saturating dropped-event counter output ovf_count.
module key_event_sched #(
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             row_rdy,
  input  logic [1:0]       row_hi,
  input  logic [3:0]       col_n,
  input  logic             flush,
  output logic             key_valid,
  output logic [3:0]       key_code,
  input  logic             key_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             busy,
`ifdef KEYSCHED_OVF_CNT_EN
  output logic [7:0]       ovf_count,
`endif
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SER  = 1'b1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [0:0]       state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       rowq_q, rowq_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q;
  logic             push_s, pop_s, wr_s, full_s, code_drop_s, row_drop_s;
  logic [1:0]       col_idx_s;

  // Serialiser FSM: latch a row's press bits, then emit one code per cycle, lowest column first.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rowq_d     = rowq_q;
    push_s     = 1'b0;
    col_idx_s  = 2'd0;
    row_drop_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (row_rdy && (col_n != 4'hF)) begin
          pend_d  = ~col_n;
          rowq_d  = row_hi;
          state_d = S_SER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SER: begin
        push_s     = 1'b1;
        row_drop_s = row_rdy;
        if (pend_q[0])      col_idx_s = 2'd0;
        else if (pend_q[1]) col_idx_s = 2'd1;
        else if (pend_q[2]) col_idx_s = 2'd2;
        else                col_idx_s = 2'd3;
        pend_d = pend_q & (pend_q - 4'd1);
        if (pend_d == 4'd0) state_d = S_IDLE;
        else                state_d = S_SER;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 4'd0;
      end
    endcase
  end

  assign full_s      = (level_q == FULL_LVL);
  assign pop_s       = key_valid & key_ready;
  assign wr_s        = push_s & (~full_s | pop_s);
  assign code_drop_s = push_s & full_s & ~pop_s;

  // FIFO occupancy: a push into a full FIFO only lands when a pop frees the head slot.
  always_comb begin
    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State, FIFO storage and sticky overflow; flush outranks every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 4'd0;
      rowq_q   <= 2'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
    end else if (flush) begin
      state_q  <= S_IDLE;
      pend_q   <= 4'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rowq_q  <= rowq_d;
      level_q <= level_d;
      if (wr_s) begin
        mem_q[wr_ptr_q] <= {rowq_q, col_idx_s};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (code_drop_s || row_drop_s) ovf_q <= 1'b1;
    end
  end

`ifdef KEYSCHED_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;
  logic [8:0] ovf_sum_s;

  assign ovf_sum_s = {1'b0, ovf_cnt_q} + {7'd0, code_drop_s} + {7'd0, row_drop_s};

  // Saturating count of dropped codes and dropped row results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ovf_cnt_q <= 8'd0;
    else if (flush)        ovf_cnt_q <= 8'd0;
    else if (ovf_sum_s[8]) ovf_cnt_q <= 8'hFF;
    else                   ovf_cnt_q <= ovf_sum_s[7:0];
  end

  assign ovf_count = ovf_cnt_q;
`endif

  assign key_valid  = (level_q != '0);
  assign key_code   = key_valid ? mem_q[rd_ptr_q] : 4'd0;
  assign fifo_level = level_q;
  assign busy       = (state_q == S_SER);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_event_sched.sv
// Directed, table-driven bench for key_event_sched (FIFO_DEPTH=8).
module tb_key_event_sched;

  logic       clk = 1'b0;
  logic       rst_n, row_rdy, flush, key_ready, key_valid, busy, overflow;
  logic [1:0] row_hi;
  logic [3:0] col_n, key_code, fifo_level;
`ifdef KEYSCHED_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  key_event_sched #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .row_rdy(row_rdy), .row_hi(row_hi), .col_n(col_n),
    .flush(flush), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .fifo_level(fifo_level), .busy(busy),
`ifdef KEYSCHED_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rr; logic [1:0] hi; logic [3:0] col; logic kr; logic fl;
    logic       ev; logic [3:0] ec; logic [3:0] el; logic eb; logic eo; logic [7:0] ecnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rr, input logic [1:0] hi, input logic [3:0] col,
                     input logic kr, input logic fl, input logic ev, input logic [3:0] ec,
                     input logic [3:0] el, input logic eb, input logic eo, input logic [7:0] ecnt);
    vec_t v;
    v = '{rr, hi, col, kr, fl, ev, ec, el, eb, eo, ecnt};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [3:0] ec,
                         input logic [3:0] el, input logic eb, input logic eo);
    chk({tag, ".valid"}, int'(key_valid), int'(ev));
    chk({tag, ".code"},  int'(key_code),  int'(ec));
    chk({tag, ".level"}, int'(fifo_level), int'(el));
    chk({tag, ".busy"},  int'(busy),      int'(eb));
    chk({tag, ".ovf"},   int'(overflow),  int'(eo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; row_rdy = 1'b0; row_hi = 2'd0; col_n = 4'hF; flush = 1'b0; key_ready = 1'b0;

    // test 1
    add(1'b1, 2'd2, 4'b1101, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h9, 4'd1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 8'd0);
    // test 2
    add(1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h4, 4'd1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h4, 4'd2, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h4, 4'd3, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h4, 4'd4, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h5, 4'd3, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h6, 4'd2, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h7, 4'd1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 8'd0);
    // test 3: rows 0, 2, 3 with all columns pressed, no draining
    add(1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd2, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd4, 1'b0, 1'b0, 8'd0);
    add(1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h0, 4'd4, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd6, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd7, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b0, 1'b0, 8'd0);
    add(1'b1, 2'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b1, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b1, 1'b1, 8'd1);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b1, 1'b1, 8'd2);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b1, 1'b1, 8'd3);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b0, 1'b1, 8'd4);
    // test 4: full FIFO, push of code 4 coincides with a pop, then drain everything
    add(1'b1, 2'd1, 4'b1110, 1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 1'b1, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h1, 4'd8, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h2, 4'd7, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h3, 4'd6, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h8, 4'd5, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h9, 4'd4, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'hA, 4'd3, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'hB, 4'd2, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b1, 4'h4, 4'd1, 1'b0, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 8'd4);
    // test 5: flush in the second SER cycle
    add(1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b1, 4'h0, 4'd1, 1'b1, 1'b1, 8'd4);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd0, 4'hF,    1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 8'd0);

    tick();
    tick();
    chk_all("reset", 1'b0, 4'h0, 4'd0, 1'b0, 1'b0);
`ifdef KEYSCHED_OVF_CNT_EN
    chk("reset.cnt", int'(ovf_count), 0);
`endif
    rst_n = 1'b1;
    tick();

    foreach (vq[i]) begin
      row_rdy = vq[i].rr; row_hi = vq[i].hi; col_n = vq[i].col;
      key_ready = vq[i].kr; flush = vq[i].fl;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].ec, vq[i].el, vq[i].eb, vq[i].eo);
`ifdef KEYSCHED_OVF_CNT_EN
      chk($sformatf("vec%0d.cnt", i), int'(ovf_count), int'(vq[i].ecnt));
`endif
    end

    // test 6: reset in the middle of serialising row 3 with three codes queued
    row_rdy = 1'b1; row_hi = 2'd3; col_n = 4'b0000; key_ready = 1'b0; flush = 1'b0;
    tick();
    row_rdy = 1'b0; col_n = 4'hF;
    tick();
    tick();
    tick();
    chk_all("t6.pre", 1'b1, 4'hC, 4'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("t6.rst", 1'b0, 4'h0, 4'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk_all("t6.idle", 1'b0, 4'h0, 4'd0, 1'b0, 1'b0);
    row_rdy = 1'b1; row_hi = 2'd2; col_n = 4'b1101; key_ready = 1'b1;
    tick();
    chk_all("t6.ser", 1'b0, 4'h0, 4'd0, 1'b1, 1'b0);
    row_rdy = 1'b0; col_n = 4'hF;
    tick();
    chk_all("t6.push", 1'b1, 4'h9, 4'd1, 1'b0, 1'b0);
    tick();
    chk_all("t6.pop", 1'b0, 4'h0, 4'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
